// File: rtl/ederah_kernel_rd_scheduler.sv
// AXI4 read-address sequencer for a kernel read master.
// Splits a start/length command into fixed-size bursts, issues them on AR,
// limits in-flight bursts with an outstanding counter and pulses done once
// every burst has returned its last beat.
module ederah_kernel_rd_scheduler #(
    parameter int C_ADDR_WIDTH      = 64,
    parameter int C_DATA_WIDTH      = 512,
    parameter int C_XFER_SIZE_WIDTH = 32,
    parameter int C_MAX_BURST       = 64,
    parameter int C_MAX_OUTSTANDING = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ctrl_start,
    input  logic [C_ADDR_WIDTH-1:0]      ctrl_addr_offset,
    input  logic [C_XFER_SIZE_WIDTH-1:0] ctrl_xfer_beats,
    output logic                         ctrl_busy,
    output logic                         ctrl_done,
    output logic                         m_axi_arvalid,
    input  logic                         m_axi_arready,
    output logic [C_ADDR_WIDTH-1:0]      m_axi_araddr,
    output logic [7:0]                   m_axi_arlen,
    input  logic                         r_beat_last
);

    localparam int LP_BPB    = C_DATA_WIDTH / 8;
    localparam int LP_STRIDE = C_MAX_BURST * LP_BPB;
    localparam int LP_CNT_W  = $clog2(C_MAX_OUTSTANDING + 1);

    localparam logic [C_XFER_SIZE_WIDTH-1:0] LP_BURST_BEATS = C_XFER_SIZE_WIDTH'(C_MAX_BURST);
    localparam logic [C_XFER_SIZE_WIDTH-1:0] LP_ONE_BURST   = C_XFER_SIZE_WIDTH'(1);
    localparam logic [C_XFER_SIZE_WIDTH-1:0] LP_TWO_BURSTS  = C_XFER_SIZE_WIDTH'(2);
    localparam logic [C_ADDR_WIDTH-1:0]      LP_ADDR_STEP   = C_ADDR_WIDTH'(LP_STRIDE);
    localparam logic [LP_CNT_W-1:0]          LP_CNT_CAP     = LP_CNT_W'(C_MAX_OUTSTANDING);
    localparam logic [LP_CNT_W-1:0]          LP_CNT_ONE     = LP_CNT_W'(1);
    localparam logic [7:0]                   LP_FULL_LEN    = 8'(C_MAX_BURST - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                         state;
    state_t                         state_next;

    logic [C_ADDR_WIDTH-1:0]        araddr_q;
    logic [7:0]                     arlen_q;
    logic [7:0]                     last_len_q;
    logic [C_XFER_SIZE_WIDTH-1:0]   bursts_left;
    logic [LP_CNT_W-1:0]            out_cnt;
    logic [LP_CNT_W-1:0]            out_cnt_next;

    logic                           ar_hs;
    logic                           r_dec;
    logic                           start_ok;
    logic [C_XFER_SIZE_WIDTH-1:0]   start_rem;
    logic [C_XFER_SIZE_WIDTH-1:0]   start_bursts;
    logic [7:0]                     start_last_len;

    assign m_axi_arvalid = (state == S_ISSUE) && (out_cnt != LP_CNT_CAP);
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = arlen_q;
    assign ctrl_busy     = (state != S_IDLE);
    assign ctrl_done     = (state == S_DONE);

    assign ar_hs    = m_axi_arvalid && m_axi_arready;
    assign r_dec    = r_beat_last && (out_cnt != '0);
    assign start_ok = (state == S_IDLE) && ctrl_start;

    // Burst count and tail length derived from the requested beat count.
    always_comb begin
        start_rem      = ctrl_xfer_beats % LP_BURST_BEATS;
        start_bursts   = (ctrl_xfer_beats / LP_BURST_BEATS)
                       + C_XFER_SIZE_WIDTH'(start_rem != '0);
        start_last_len = (start_rem == '0) ? LP_FULL_LEN : 8'(start_rem - LP_ONE_BURST);
    end

    // Outstanding-burst counter update: +1 on AR handshake, -1 on last beat.
    always_comb begin
        out_cnt_next = out_cnt;
        if (ar_hs && !r_dec) begin
            out_cnt_next = out_cnt + LP_CNT_ONE;
        end else if (!ar_hs && r_dec) begin
            out_cnt_next = out_cnt - LP_CNT_ONE;
        end
    end

    // Next-state logic for the command sequencer.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (ctrl_start) begin
                    state_next = (ctrl_xfer_beats == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (ar_hs && (bursts_left == LP_ONE_BURST)) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_cnt_next == '0) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Outstanding counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_cnt <= '0;
        end else begin
            out_cnt <= out_cnt_next;
        end
    end

    // Burst datapath: capture on start, advance address/length on each handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            araddr_q    <= '0;
            arlen_q     <= '0;
            last_len_q  <= '0;
            bursts_left <= '0;
        end else if (start_ok) begin
            araddr_q    <= ctrl_addr_offset;
            arlen_q     <= (start_bursts == LP_ONE_BURST) ? start_last_len : LP_FULL_LEN;
            last_len_q  <= start_last_len;
            bursts_left <= start_bursts;
        end else if (ar_hs) begin
            araddr_q    <= araddr_q + LP_ADDR_STEP;
            // The burst after this handshake is the final one when two remain now.
            arlen_q     <= (bursts_left == LP_TWO_BURSTS) ? last_len_q : LP_FULL_LEN;
            bursts_left <= bursts_left - LP_ONE_BURST;
        end
    end

endmodule

// File: tb/tb_ederah_kernel_rd_scheduler.sv
// Self-checking bench for ederah_kernel_rd_scheduler (64-beat bursts,
// 512-bit data, cap of two outstanding bursts).
module tb_ederah_kernel_rd_scheduler;

    localparam int unsigned CAP    = 2;
    localparam int unsigned BURST  = 64;
    localparam int unsigned STRIDE = 4096;

    logic        clk;
    logic        rst_n;
    logic        ctrl_start;
    logic [63:0] ctrl_addr_offset;
    logic [31:0] ctrl_xfer_beats;
    logic        ctrl_busy;
    logic        ctrl_done;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [63:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic        r_beat_last;

    int errors = 0;
    int checks = 0;

    ederah_kernel_rd_scheduler #(
        .C_ADDR_WIDTH      (64),
        .C_DATA_WIDTH      (512),
        .C_XFER_SIZE_WIDTH (32),
        .C_MAX_BURST       (64),
        .C_MAX_OUTSTANDING (2)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ctrl_start       (ctrl_start),
        .ctrl_addr_offset (ctrl_addr_offset),
        .ctrl_xfer_beats  (ctrl_xfer_beats),
        .ctrl_busy        (ctrl_busy),
        .ctrl_done        (ctrl_done),
        .m_axi_arvalid    (m_axi_arvalid),
        .m_axi_arready    (m_axi_arready),
        .m_axi_araddr     (m_axi_araddr),
        .m_axi_arlen      (m_axi_arlen),
        .r_beat_last      (r_beat_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse start for one cycle; returns at the negedge of the first cycle after acceptance.
    task automatic start_xfer(input logic [63:0] a, input logic [31:0] b);
        @(negedge clk);
        ctrl_start       = 1'b1;
        ctrl_addr_offset = a;
        ctrl_xfer_beats  = b;
        @(negedge clk);
        ctrl_start = 1'b0;
    endtask

    // Stimulus only: accept every AR and return last beats until done or budget runs out.
    task automatic drain(input int unsigned outst_in, output bit finished);
        int unsigned outst;
        bit rl;
        outst    = outst_in;
        finished = 1'b0;
        for (int unsigned c = 0; c < 400 && !finished; c++) begin
            m_axi_arready = 1'b1;
            rl            = (outst > 0);
            r_beat_last   = rl;
            #1;
            if (ctrl_done) begin
                finished = 1'b1;
            end else begin
                if (m_axi_arvalid && !rl) outst++;
                else if (!m_axi_arvalid && rl) outst--;
            end
            @(negedge clk);
        end
        r_beat_last = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (m_axi_arvalid !== 1'b0) begin errors++; $display("FAIL reset_arvalid: got %b expected 0", m_axi_arvalid); end
        checks++; if (m_axi_araddr !== 64'h0) begin errors++; $display("FAIL reset_araddr: got %h expected 0", m_axi_araddr); end
        checks++; if (m_axi_arlen !== 8'h0) begin errors++; $display("FAIL reset_arlen: got %h expected 0", m_axi_arlen); end
        checks++; if (ctrl_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", ctrl_busy); end
        checks++; if (ctrl_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", ctrl_done); end
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checks++; if ({ctrl_busy, ctrl_done, m_axi_arvalid} !== 3'b000) begin errors++; $display("FAIL post_reset_idle: got %b expected 000", {ctrl_busy, ctrl_done, m_axi_arvalid}); end
        @(negedge clk);
    endtask

    task automatic test_multi_burst();
        logic [63:0] exp_addr [4];
        logic [7:0]  exp_len  [4];
        int unsigned due_q [$];
        int unsigned n_ar, n_rl, cyc, rl4_cyc, done_cyc;
        bit          done_seen;
        exp_addr[0] = 64'h1000; exp_len[0] = 8'd63;
        exp_addr[1] = 64'h2000; exp_len[1] = 8'd63;
        exp_addr[2] = 64'h3000; exp_len[2] = 8'd63;
        exp_addr[3] = 64'h4000; exp_len[3] = 8'd7;
        n_ar = 0; n_rl = 0; rl4_cyc = 0; done_cyc = 0; done_seen = 1'b0;
        m_axi_arready = 1'b1;
        r_beat_last   = 1'b0;
        start_xfer(64'h1000, 32'd200);
        cyc = 1;
        while (!done_seen && cyc < 300) begin
            r_beat_last = 1'b0;
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                r_beat_last = 1'b1;
                void'(due_q.pop_front());
                n_rl++;
                if (n_rl == 4) rl4_cyc = cyc;
            end
            #1;
            if (cyc == 1) begin
                checks++; if (m_axi_arvalid !== 1'b1) begin errors++; $display("FAIL multi_first_ar_latency: got %b expected 1", m_axi_arvalid); end
                checks++; if (ctrl_busy !== 1'b1) begin errors++; $display("FAIL multi_busy: got %b expected 1", ctrl_busy); end
            end
            if (ctrl_done) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
            end
            if (m_axi_arvalid) begin
                if (n_ar < 4) begin
                    checks++; if (m_axi_araddr !== exp_addr[n_ar]) begin errors++; $display("FAIL multi_araddr[%0d]: got %h expected %h", n_ar, m_axi_araddr, exp_addr[n_ar]); end
                    checks++; if (m_axi_arlen !== exp_len[n_ar]) begin errors++; $display("FAIL multi_arlen[%0d]: got %0d expected %0d", n_ar, m_axi_arlen, exp_len[n_ar]); end
                end else begin
                    checks++; errors++;
                    $display("FAIL multi_extra_ar: got AR #%0d expected 4 in total", n_ar + 1);
                end
                due_q.push_back(cyc + 10);
                n_ar++;
            end
            @(negedge clk);
            cyc++;
        end
        r_beat_last = 1'b0;
        checks++; if (!done_seen || done_cyc != rl4_cyc + 1) begin errors++; $display("FAIL multi_done_timing: got cycle %0d (seen=%0b) expected %0d", done_cyc, done_seen, rl4_cyc + 1); end
        checks++; if (n_ar != 4) begin errors++; $display("FAIL multi_ar_count: got %0d expected 4", n_ar); end
    endtask

    task automatic test_zero_len();
        m_axi_arready = 1'b1;
        r_beat_last   = 1'b0;
        start_xfer(64'h5000, 32'd0);
        for (int unsigned c = 1; c <= 4; c++) begin
            #1;
            checks++; if (m_axi_arvalid !== 1'b0) begin errors++; $display("FAIL zero_arvalid[%0d]: got %b expected 0", c, m_axi_arvalid); end
            checks++; if (ctrl_done !== (c == 1)) begin errors++; $display("FAIL zero_done[%0d]: got %b expected %b", c, ctrl_done, (c == 1)); end
            if (c > 1) begin
                checks++; if (ctrl_busy !== 1'b0) begin errors++; $display("FAIL zero_busy[%0d]: got %b expected 0", c, ctrl_busy); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_outstanding_cap();
        int unsigned n_ar;
        bit fin;
        n_ar          = 0;
        m_axi_arready = 1'b1;
        r_beat_last   = 1'b0;
        start_xfer(64'h10000, 32'd256);
        for (int unsigned c = 0; c < 10; c++) begin
            #1;
            if (m_axi_arvalid) n_ar++;
            @(negedge clk);
        end
        checks++; if (n_ar != CAP) begin errors++; $display("FAIL cap_ar_count: got %0d expected %0d", n_ar, CAP); end
        #1;
        checks++; if (m_axi_arvalid !== 1'b0) begin errors++; $display("FAIL cap_arvalid_held: got %b expected 0", m_axi_arvalid); end
        checks++; if (ctrl_busy !== 1'b1) begin errors++; $display("FAIL cap_busy: got %b expected 1", ctrl_busy); end
        r_beat_last = 1'b1;
        #1;
        checks++; if (m_axi_arvalid !== 1'b0) begin errors++; $display("FAIL cap_arvalid_same_cycle: got %b expected 0", m_axi_arvalid); end
        @(negedge clk);
        r_beat_last = 1'b0;
        #1;
        checks++; if (m_axi_arvalid !== 1'b1) begin errors++; $display("FAIL cap_third_arvalid: got %b expected 1", m_axi_arvalid); end
        checks++; if (m_axi_araddr !== 64'h12000) begin errors++; $display("FAIL cap_third_araddr: got %h expected 12000", m_axi_araddr); end
        @(negedge clk);
        drain(CAP, fin);
        checks++; if (!fin) begin errors++; $display("FAIL cap_completion: got no done expected done"); end
    endtask

    task automatic test_backpressure();
        bit fin;
        r_beat_last   = 1'b0;
        m_axi_arready = 1'b1;
        start_xfer(64'h20000, 32'd128);
        #1;
        checks++; if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== 64'h20000) begin errors++; $display("FAIL bp_burst0: got v=%b a=%h expected v=1 a=20000", m_axi_arvalid, m_axi_araddr); end
        for (int unsigned c = 0; c < 5; c++) begin
            @(negedge clk);
            m_axi_arready = 1'b0;
            #1;
            checks++; if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== 64'h21000 || m_axi_arlen !== 8'd63) begin errors++; $display("FAIL bp_stable[%0d]: got v=%b a=%h l=%0d expected v=1 a=21000 l=63", c, m_axi_arvalid, m_axi_araddr, m_axi_arlen); end
        end
        @(negedge clk);
        m_axi_arready = 1'b1;
        #1;
        checks++; if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== 64'h21000) begin errors++; $display("FAIL bp_handshake: got v=%b a=%h expected v=1 a=21000", m_axi_arvalid, m_axi_araddr); end
        @(negedge clk);
        #1;
        checks++; if (m_axi_arvalid !== 1'b0) begin errors++; $display("FAIL bp_no_extra_burst: got %b expected 0", m_axi_arvalid); end
        drain(2, fin);
        checks++; if (!fin) begin errors++; $display("FAIL bp_completion: got no done expected done"); end
    endtask

    task automatic test_simultaneous();
        bit fin;
        m_axi_arready = 1'b1;
        // Stray last beat with nothing outstanding must be ignored.
        @(negedge clk);
        r_beat_last = 1'b1;
        @(negedge clk);
        r_beat_last = 1'b0;
        start_xfer(64'h30000, 32'd256);
        // cycle 1: first AR, plus a start that must be ignored
        ctrl_start       = 1'b1;
        ctrl_addr_offset = 64'h90000;
        ctrl_xfer_beats  = 32'd5;
        #1;
        checks++; if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== 64'h30000) begin errors++; $display("FAIL sim_burst0: got v=%b a=%h expected v=1 a=30000", m_axi_arvalid, m_axi_araddr); end
        @(negedge clk);
        // cycle 2: handshake and last beat together
        ctrl_start  = 1'b0;
        r_beat_last = 1'b1;
        #1;
        checks++; if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== 64'h31000) begin errors++; $display("FAIL sim_ignored_start: got v=%b a=%h expected v=1 a=31000", m_axi_arvalid, m_axi_araddr); end
        @(negedge clk);
        r_beat_last = 1'b0;
        #1;
        checks++; if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== 64'h32000) begin errors++; $display("FAIL sim_count_unchanged: got v=%b a=%h expected v=1 a=32000", m_axi_arvalid, m_axi_araddr); end
        @(negedge clk);
        #1;
        checks++; if (m_axi_arvalid !== 1'b0) begin errors++; $display("FAIL sim_cap_reached: got %b expected 0", m_axi_arvalid); end
        r_beat_last = 1'b1;
        @(negedge clk);
        r_beat_last = 1'b0;
        #1;
        checks++; if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== 64'h33000 || m_axi_arlen !== 8'd63) begin errors++; $display("FAIL sim_last_burst: got v=%b a=%h l=%0d expected v=1 a=33000 l=63", m_axi_arvalid, m_axi_araddr, m_axi_arlen); end
        @(negedge clk);
        drain(2, fin);
        checks++; if (!fin) begin errors++; $display("FAIL sim_completion: got no done expected done"); end
    endtask

    task automatic test_reset_mid();
        bit fin;
        m_axi_arready = 1'b1;
        r_beat_last   = 1'b0;
        start_xfer(64'h40000, 32'd256);
        repeat (2) @(negedge clk);
        #1;
        checks++; if (ctrl_busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_before: got %b expected 1", ctrl_busy); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if ({m_axi_arvalid, ctrl_busy, ctrl_done} !== 3'b000) begin errors++; $display("FAIL rmid_async_drop: got %b expected 000", {m_axi_arvalid, ctrl_busy, ctrl_done}); end
        checks++; if (m_axi_araddr !== 64'h0 || m_axi_arlen !== 8'h0) begin errors++; $display("FAIL rmid_ar_cleared: got a=%h l=%0d expected 0", m_axi_araddr, m_axi_arlen); end
        @(negedge clk);
        rst_n = 1'b1;
        start_xfer(64'h50000, 32'd64);
        #1;
        checks++; if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== 64'h50000 || m_axi_arlen !== 8'd63) begin errors++; $display("FAIL rmid_single_ar: got v=%b a=%h l=%0d expected v=1 a=50000 l=63", m_axi_arvalid, m_axi_araddr, m_axi_arlen); end
        @(negedge clk);
        #1;
        checks++; if (m_axi_arvalid !== 1'b0) begin errors++; $display("FAIL rmid_no_second_ar: got %b expected 0", m_axi_arvalid); end
        drain(1, fin);
        checks++; if (!fin) begin errors++; $display("FAIL rmid_completion: got no done expected done"); end
    endtask

    // Random transfers against a transaction-level model: expected bursts come
    // from ceil(beats/64) with a (beats-1)%64 tail, and the in-flight count is
    // a plain integer bounded by CAP.
    task automatic test_random();
        logic [63:0] base;
        int unsigned beats, nb, issued, outst, cyc;
        bit active, done_due, rl, hs, exp_v;
        logic [63:0] exp_a;
        logic [7:0]  exp_l;
        for (int unsigned t = 0; t < 24; t++) begin
            base  = 64'($urandom_range(0, 255)) << 12;
            beats = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 400);
            nb    = (beats + BURST - 1) / BURST;
            r_beat_last = 1'b0;
            @(negedge clk);
            ctrl_start       = 1'b1;
            ctrl_addr_offset = base;
            ctrl_xfer_beats  = beats;
            #1;
            checks++; if ({m_axi_arvalid, ctrl_busy, ctrl_done} !== 3'b000) begin errors++; $display("FAIL rand_idle[%0d]: got %b expected 000", t, {m_axi_arvalid, ctrl_busy, ctrl_done}); end
            @(negedge clk);
            active = (nb > 0); done_due = (nb == 0); issued = 0; outst = 0; cyc = 0;
            while (cyc < 2000) begin
                m_axi_arready = ($urandom_range(0, 9) < 7);
                rl = (outst > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 9) == 0);
                r_beat_last = rl;
                if (active && $urandom_range(0, 9) == 0) begin
                    ctrl_start       = 1'b1;
                    ctrl_addr_offset = 64'($urandom_range(0, 255)) << 12;
                    ctrl_xfer_beats  = $urandom_range(0, 400);
                end else begin
                    ctrl_start = 1'b0;
                end
                #1;
                exp_v = active && (issued < nb) && (outst < CAP);
                checks++; if (m_axi_arvalid !== exp_v) begin errors++; $display("FAIL rand_arvalid[%0d.%0d]: got %b expected %b", t, cyc, m_axi_arvalid, exp_v); end
                if (exp_v) begin
                    exp_a = base + 64'(issued) * 64'(STRIDE);
                    exp_l = (issued == nb - 1) ? 8'((beats - 1) % BURST) : 8'(BURST - 1);
                    checks++; if (m_axi_araddr !== exp_a || m_axi_arlen !== exp_l) begin errors++; $display("FAIL rand_ar[%0d.%0d]: got a=%h l=%0d expected a=%h l=%0d", t, cyc, m_axi_araddr, m_axi_arlen, exp_a, exp_l); end
                end
                checks++; if (ctrl_done !== done_due) begin errors++; $display("FAIL rand_done[%0d.%0d]: got %b expected %b", t, cyc, ctrl_done, done_due); end
                if (!done_due) begin
                    checks++; if (ctrl_busy !== active) begin errors++; $display("FAIL rand_busy[%0d.%0d]: got %b expected %b", t, cyc, ctrl_busy, active); end
                end
                if (done_due) break;
                hs = exp_v && m_axi_arready;
                if (hs) issued++;
                if (hs && !(rl && outst > 0)) outst++;
                else if (!hs && rl && outst > 0) outst--;
                if (active && issued == nb && outst == 0) begin
                    active   = 1'b0;
                    done_due = 1'b1;
                end
                @(negedge clk);
                cyc++;
            end
            checks++; if (cyc >= 2000) begin errors++; $display("FAIL rand_timeout[%0d]: got no done after %0d cycles expected done", t, cyc); end
            ctrl_start  = 1'b0;
            r_beat_last = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n            = 1'b0;
        ctrl_start       = 1'b0;
        ctrl_addr_offset = '0;
        ctrl_xfer_beats  = '0;
        m_axi_arready    = 1'b0;
        r_beat_last      = 1'b0;
        test_reset();
        test_multi_burst();
        test_zero_len();
        test_outstanding_cap();
        test_backpressure();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
